// File: rtl/glb_stream_pkg.sv
// ============================================================================
// Module  : glb_stream_pkg
// Brief   : Shared types and helpers for the GLB read-side stream sink.
// Revision: 1.0
// ============================================================================
`default_nettype none

package glb_stream_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RECV  = 2'd2,
    DONE  = 2'd3
  } glb_rd_state_t;

  function automatic logic hs_fire(input logic i_valid, input logic i_ready);
    return i_valid & i_ready;
  endfunction

endpackage

`default_nettype wire

// File: rtl/glb_ready_shaper.sv
// ============================================================================
// Module  : glb_ready_shaper
// Brief   : Cycles a 4-bit pointer through a 16-bit mask to shape sink ready.
// Revision: 1.0
// ============================================================================
`default_nettype none

module glb_ready_shaper #(
  parameter logic [15:0] READY_MASK = 16'hFFFF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic ready
);

  logic [3:0] r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 4'd0;
    end else if (clr) begin
      r_ptr <= 4'd0;
    end else if (en) begin
      r_ptr <= r_ptr + 4'd1;
    end
  end

  // Gated by en so ready falls as soon as the state register leaves RECV.
  assign ready = en & READY_MASK[r_ptr];

endmodule

`default_nettype wire

// File: rtl/glb_read_sink.sv
// ============================================================================
// Module  : glb_read_sink
// Brief   : Valid/ready stream sink capturing a tile output into a local RAM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module glb_read_sink
  import glb_stream_pkg::*;
#(
  parameter int          TX_SIZE    = 32,
  parameter int          DEPTH      = 1024,
  parameter logic [15:0] READY_MASK = 16'hFFFF,
  localparam int         CW         = $clog2(DEPTH + 1),
  localparam int         AW         = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  input  logic              in_done,
  output logic              done,
  output logic [CW-1:0]     count,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  if ((TX_SIZE > DEPTH) || (TX_SIZE == 0) || (DEPTH < 2)) begin : g_bad_param
    $error("glb_read_sink: TX_SIZE must satisfy 1 <= TX_SIZE <= DEPTH");
  end

  localparam logic [CW-1:0] c_last = CW'(TX_SIZE - 1);

  glb_rd_state_t     r_state;
  glb_rd_state_t     w_state_next;
  logic [CW-1:0]     r_count;
  logic              r_done;
  logic [DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_ready;
  logic              w_xfer;

  glb_ready_shaper #(
    .READY_MASK (READY_MASK)
  ) u_shaper (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (r_state == RECV),
    .clr   (r_state == FLUSH),
    .ready (w_ready)
  );

  assign w_xfer = hs_fire(valid, w_ready);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (flush) w_state_next = FLUSH;
      FLUSH:   if (!flush) w_state_next = RECV;
      RECV:    if ((w_xfer && (r_count == c_last)) || in_done) w_state_next = DONE;
      DONE:    w_state_next = DONE;
      default: w_state_next = IDLE;
    endcase
    // A flush restarts the capture from any state, abandoning partial data.
    if (flush) w_state_next = FLUSH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= (w_state_next == DONE);
      if (r_state == FLUSH) begin
        r_count <= '0;
      end else if (w_xfer) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  // Capture RAM has no reset so it maps onto block memory.
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_mem[r_count[AW-1:0]] <= data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign ready   = w_ready;
  assign done    = r_done;
  assign count   = r_count;
  assign rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: tb/tb_glb_read_sink.sv
// ============================================================================
// Module  : tb_glb_read_sink
// Brief   : Scoreboard bench for glb_read_sink (full-rate and AAAA-shaped sinks).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_glb_read_sink;

  localparam int CW     = 11;
  localparam int AW     = 10;
  localparam int BUDGET = 400;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            valid;
  logic            in_done;
  logic [15:0]     data;
  logic [AW-1:0]   rd_addr;
  logic            ready_a, done_a, ready_b, done_b;
  logic [CW-1:0]   count_a, count_b;
  logic [15:0]     rd_a, rd_b;
  logic            sel;
  logic            s_ready, s_done;
  logic [CW-1:0]   s_count;
  logic [15:0]     s_rd;

  int              n_checks = 0;
  int              n_errors = 0;
  logic [15:0]     exp_q[$];
  int              f_c, l_c, d_c;

  always #5 clk = ~clk;

  assign s_ready = sel ? ready_b : ready_a;
  assign s_done  = sel ? done_b  : done_a;
  assign s_count = sel ? count_b : count_a;
  assign s_rd    = sel ? rd_b    : rd_a;

  glb_read_sink #(.TX_SIZE(32), .DEPTH(1024), .READY_MASK(16'hFFFF)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .data(data), .valid(valid),
    .ready(ready_a), .in_done(in_done), .done(done_a), .count(count_a),
    .rd_addr(rd_addr), .rd_data(rd_a)
  );

  glb_read_sink #(.TX_SIZE(32), .DEPTH(1024), .READY_MASK(16'hAAAA)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .data(data), .valid(valid),
    .ready(ready_b), .in_done(in_done), .done(done_b), .count(count_b),
    .rd_addr(rd_addr), .rd_data(rd_b)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  // Producer: drives words base+k, holds valid until accepted, and records
  // the cycles of the first/last transfer and of done (relative to entry).
  task automatic run_stream(input int n, input logic [15:0] base, input int drop,
                            input int idone_at, input bit idone_conc, input bit want_done,
                            output int first_c, output int last_c, output int done_c);
    int sent = 0;
    bit hold = 1'b0;
    first_c = -1;
    last_c  = -1;
    done_c  = -1;
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      @(negedge clk);
      if (s_done) begin
        done_c = cyc;
        break;
      end
      check("count_track", 32'(s_count), 32'(sent));
      in_done = 1'b0;
      if (!want_done && sent >= n) break;
      if (!hold) begin
        valid = (sent < n) && ($urandom_range(0, 99) >= drop);
        data  = base + 16'(sent);
      end
      if (idone_at >= 0 && !idone_conc && sent == idone_at) begin
        valid   = 1'b0;
        in_done = 1'b1;
      end
      if (valid && s_ready) begin
        exp_q.push_back(data);
        if (idone_conc && sent == idone_at - 1) in_done = 1'b1;
        if (sent == 0) first_c = cyc;
        last_c = cyc;
        sent++;
        hold = 1'b0;
      end else begin
        hold = valid;
      end
    end
    valid   = 1'b0;
    in_done = 1'b0;
    if (want_done && done_c < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic readback(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rd_addr = AW'(k);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        check("sb_empty", 32'd1, 32'd0);
      end else begin
        check($sformatf("rd[%0d]", k), 32'(s_rd), 32'(exp_q.pop_front()));
      end
    end
    check("sb_leftover", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; valid = 1'b0; in_done = 1'b0;
    data = '0; rd_addr = '0; sel = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_count", 32'(count_a), 32'd0);
    check("rst_rd_data", 32'(rd_a), 32'd0);
    rst_n = 1'b1;

    // Full-rate capture of 0..31
    do_flush();
    run_stream(32, 16'h0000, 0, -1, 1'b0, 1'b1, f_c, l_c, d_c);
    check("t1_first", 32'(f_c), 32'd0);
    check("t1_last", 32'(l_c), 32'd31);
    check("t1_done_lat", 32'(d_c - l_c), 32'd1);
    check("t1_count", 32'(s_count), 32'd32);
    check("t1_ready_off", 32'(s_ready), 32'd0);
    readback(32);

    // Alternate-cycle ready pattern
    sel = 1'b1;
    do_flush();
    run_stream(32, 16'h1000, 0, -1, 1'b0, 1'b1, f_c, l_c, d_c);
    check("t2_first", 32'(f_c), 32'd1);
    check("t2_last", 32'(l_c), 32'd63);
    check("t2_done", 32'(d_c), 32'd64);
    check("t2_count", 32'(s_count), 32'd32);
    readback(32);
    sel = 1'b0;

    // Random producer gaps
    do_flush();
    run_stream(32, 16'h2000, 50, -1, 1'b0, 1'b1, f_c, l_c, d_c);
    check("t3_done_lat", 32'(d_c - l_c), 32'd1);
    check("t3_count", 32'(s_count), 32'd32);
    readback(32);

    // Early end-of-stream after 10 words, then concurrent with the 10th
    do_flush();
    run_stream(10, 16'h4000, 0, 10, 1'b0, 1'b1, f_c, l_c, d_c);
    check("t4a_count", 32'(s_count), 32'd10);
    check("t4a_ready_off", 32'(s_ready), 32'd0);
    readback(10);
    do_flush();
    run_stream(10, 16'h4100, 0, 10, 1'b1, 1'b1, f_c, l_c, d_c);
    check("t4b_done_lat", 32'(d_c - l_c), 32'd1);
    check("t4b_count", 32'(s_count), 32'd10);
    check("t4b_ready_off", 32'(s_ready), 32'd0);
    readback(10);

    // Flush mid-capture discards partial data
    do_flush();
    run_stream(12, 16'h5000, 0, -1, 1'b0, 1'b0, f_c, l_c, d_c);
    exp_q.delete();
    do_flush();
    run_stream(32, 16'h0100, 0, -1, 1'b0, 1'b1, f_c, l_c, d_c);
    check("t5_first", 32'(f_c), 32'd0);
    check("t5_count", 32'(s_count), 32'd32);
    readback(32);

    // Asynchronous reset in the middle of a capture
    do_flush();
    run_stream(7, 16'h0300, 0, -1, 1'b0, 1'b0, f_c, l_c, d_c);
    exp_q.delete();
    #2 rst_n = 1'b0;
    #1;
    check("t6_ready", 32'(ready_a), 32'd0);
    check("t6_done", 32'(done_a), 32'd0);
    check("t6_count", 32'(count_a), 32'd0);
    rd_addr = AW'(3);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_rd3", 32'(rd_a), 32'h0303);
    valid = 1'b1;
    data  = 16'hDEAD;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_idle_ready", 32'(ready_a), 32'd0);
    end
    check("t6_idle_count", 32'(count_a), 32'd0);
    valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
